// File: rtl/board_ctl.sv
// Playfield occupancy board: locks falling-piece squares, detects collisions and clears full rows.
// Line clearing is built only when BOARD_LINE_CLEAR_EN is defined.
module board_ctl #(
  parameter int unsigned COLS = 10,
  parameter int unsigned ROWS = 20
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            lock_en,
  input  logic [4:0]      sq_1_col,
  input  logic [4:0]      sq_2_col,
  input  logic [4:0]      sq_3_col,
  input  logic [4:0]      sq_4_col,
  input  logic [4:0]      sq_1_row,
  input  logic [4:0]      sq_2_row,
  input  logic [4:0]      sq_3_row,
  input  logic [4:0]      sq_4_row,
  input  logic [4:0]      rd_row,
  output logic [COLS-1:0] rd_data,
  output logic            collision,
  output logic            busy,
  output logic            game_over,
  output logic [15:0]     lines_cleared
);

  typedef enum logic [1:0] {StIdle, StLock, StScan, StShift} state_t;

  state_t                    state_q, state_d;
  logic [ROWS-1:0][COLS-1:0] board_q, board_d;
  logic [ROWS-1:0][COLS-1:0] sq_mask, below;
  logic [COLS-1:0]           rd_q, rd_d;
  logic                      coll_q, coll_d;
  logic                      go_q, go_d;
  logic [4:0]                sq_col [4];
  logic [4:0]                sq_row [4];

  assign sq_col[0] = sq_1_col;
  assign sq_col[1] = sq_2_col;
  assign sq_col[2] = sq_3_col;
  assign sq_col[3] = sq_4_col;
  assign sq_row[0] = sq_1_row;
  assign sq_row[1] = sq_2_row;
  assign sq_row[2] = sq_3_row;
  assign sq_row[3] = sq_4_row;

  // Out-of-range squares never match a cell, so they vanish from both lock and collision.
  always_comb begin
    sq_mask = '0;
    for (int unsigned s = 0; s < 4; s++) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          if (sq_row[s] == 5'(r) && sq_col[s] == 5'(c)) sq_mask[r][c] = 1'b1;
        end
      end
    end
  end

  // below[r] is the row a square in row r would move into; the floor counts as full.
  always_comb begin
    below[ROWS-1] = '1;
    for (int unsigned r = 0; r + 1 < ROWS; r++) below[r] = board_q[r+1];
  end

  assign coll_d = |(sq_mask & below);

  always_comb begin
    rd_d = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (rd_row == 5'(r)) rd_d = board_q[r];
    end
  end

`ifdef BOARD_LINE_CLEAR_EN
  logic [4:0]  scan_q, scan_d;
  logic [15:0] lines_q, lines_d;
  logic        row_full;

  always_comb begin
    row_full = 1'b0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (scan_q == 5'(r)) row_full = &board_q[r];
    end
  end

  assign lines_cleared = lines_q;
`else
  assign lines_cleared = '0;
`endif

  always_comb begin
    state_d = state_q;
    board_d = board_q;
    go_d    = go_q;
`ifdef BOARD_LINE_CLEAR_EN
    scan_d  = scan_q;
    lines_d = lines_q;
`endif
    unique case (state_q)
      StIdle: if (lock_en) state_d = StLock;
      StLock: begin
        board_d = board_q | sq_mask;
        if (|sq_mask[0]) go_d = 1'b1;
`ifdef BOARD_LINE_CLEAR_EN
        scan_d  = 5'(ROWS - 1);
        state_d = StScan;
`else
        state_d = StIdle;
`endif
      end
`ifdef BOARD_LINE_CLEAR_EN
      StScan: begin
        if (row_full) state_d = StShift;
        else if (scan_q == 5'd0) state_d = StIdle;
        else scan_d = scan_q - 5'd1;
      end
      StShift: begin
        // Rows 0..scan drop by one; the scan row is rechecked since new content landed there.
        board_d[0] = '0;
        for (int unsigned r = 1; r < ROWS; r++) begin
          if (5'(r) <= scan_q) board_d[r] = board_q[r-1];
        end
        lines_d = lines_q + 16'd1;
        state_d = StScan;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      board_q <= '0;
      rd_q    <= '0;
      coll_q  <= 1'b0;
      go_q    <= 1'b0;
`ifdef BOARD_LINE_CLEAR_EN
      scan_q  <= '0;
      lines_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      rd_q    <= rd_d;
      coll_q  <= coll_d;
      go_q    <= go_d;
`ifdef BOARD_LINE_CLEAR_EN
      scan_q  <= scan_d;
      lines_q <= lines_d;
`endif
    end
  end

  assign busy      = (state_q != StIdle);
  assign rd_data   = rd_q;
  assign collision = coll_q;
  assign game_over = go_q;

endmodule

// File: tb/tb_board_ctl.sv
// Directed self-checking bench for board_ctl; expectations follow BOARD_LINE_CLEAR_EN when defined.
module tb_board_ctl;
  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int NR   = 31;  // row index that is always off the board

  logic            pclk = 1'b0;
  logic            rst;
  logic            lock_en;
  logic [4:0]      sc [4];
  logic [4:0]      sr [4];
  logic [4:0]      rd_row;
  logic [COLS-1:0] rd_data;
  logic            collision, busy, game_over;
  logic [15:0]     lines_cleared;

  int n_checks = 0;
  int n_errors = 0;

  board_ctl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .pclk          (pclk),
    .rst           (rst),
    .lock_en       (lock_en),
    .sq_1_col      (sc[0]),
    .sq_2_col      (sc[1]),
    .sq_3_col      (sc[2]),
    .sq_4_col      (sc[3]),
    .sq_1_row      (sr[0]),
    .sq_2_row      (sr[1]),
    .sq_3_row      (sr[2]),
    .sq_4_row      (sr[3]),
    .rd_row        (rd_row),
    .rd_data       (rd_data),
    .collision     (collision),
    .busy          (busy),
    .game_over     (game_over),
    .lines_cleared (lines_cleared)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_sq(input int r0, input int c0, input int r1, input int c1,
                        input int r2, input int c2, input int r3, input int c3);
    sr[0] = 5'(r0); sc[0] = 5'(c0);
    sr[1] = 5'(r1); sc[1] = 5'(c1);
    sr[2] = 5'(r2); sc[2] = 5'(c2);
    sr[3] = 5'(r3); sc[3] = 5'(c3);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    if (busy) check("busy_timeout", 32'(busy), 32'(0));
  endtask

  // Pulse lock_en with squares already set; cyc = edges from the lock_en edge until busy is low.
  task automatic lock(output int cyc);
    int n;
    lock_en = 1'b1;
    tick();
    lock_en = 1'b0;
    check("busy_after_lock_en", 32'(busy), 32'(1));
    wait_idle(n);
    cyc = n + 1;
    set_sq(NR, 0, NR, 0, NR, 0, NR, 0);
  endtask

  task automatic read_row(input int r, output logic [COLS-1:0] d);
    rd_row = 5'(r);
    tick();
    d = rd_data;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  int              cyc;
  logic [COLS-1:0] d;

  initial begin
    rst     = 1'b1;
    lock_en = 1'b0;
    rd_row  = '0;
    set_sq(NR, 0, NR, 0, NR, 0, NR, 0);
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_game_over", 32'(game_over), 32'(0));
    check("rst_lines", 32'(lines_cleared), 32'(0));
    check("rst_collision", 32'(collision), 32'(0));
    check("rst_rd_data", 32'(rd_data), 32'(0));
    rst = 1'b0;
    tick();

    // O piece at the bottom-left corner
    set_sq(19, 0, 19, 1, 18, 0, 18, 1);
    lock(cyc);
`ifdef BOARD_LINE_CLEAR_EN
    check("o_cycles", 32'(cyc), 32'(22));
`else
    check("o_cycles", 32'(cyc), 32'(2));
`endif
    read_row(19, d); check("o_row19", 32'(d), 32'(10'h003));
    read_row(18, d); check("o_row18", 32'(d), 32'(10'h003));
    read_row(17, d); check("o_row17", 32'(d), 32'(0));
    check("o_lines", 32'(lines_cleared), 32'(0));

    // Fill row 19 cols 2..5, then an I piece completes it
    set_sq(19, 2, 19, 3, 19, 4, 19, 5);
    lock(cyc);
    read_row(19, d); check("pre_i_row19", 32'(d), 32'(10'h03F));
    set_sq(19, 6, 19, 7, 19, 8, 19, 9);
    lock(cyc);
    read_row(20, d); check("rd_row_out_of_range", 32'(d), 32'(0));
`ifdef BOARD_LINE_CLEAR_EN
    read_row(19, d); check("i_row19", 32'(d), 32'(10'h003));
    read_row(18, d); check("i_row18", 32'(d), 32'(0));
    check("i_lines", 32'(lines_cleared), 32'(1));
`else
    read_row(19, d); check("i_row19", 32'(d), 32'(10'h3FF));
    read_row(18, d); check("i_row18", 32'(d), 32'(10'h003));
    check("i_lines", 32'(lines_cleared), 32'(0));
`endif

    // Four rows of nine cells, then a vertical I in column 9
    do_reset();
    for (int r = 16; r < 20; r++) begin
      set_sq(r, 0, r, 1, r, 2, r, 3); lock(cyc);
      set_sq(r, 4, r, 5, r, 6, r, 7); lock(cyc);
    end
    set_sq(16, 8, 17, 8, 18, 8, 19, 8); lock(cyc);
    read_row(16, d); check("tetris_pre_row16", 32'(d), 32'(10'h1FF));
    set_sq(16, 9, 17, 9, 18, 9, 19, 9); lock(cyc);
    check("tetris_bound", 32'(cyc <= 2 * ROWS + 6), 32'(1));
`ifdef BOARD_LINE_CLEAR_EN
    check("tetris_cycles", 32'(cyc), 32'(30));
    check("tetris_lines", 32'(lines_cleared), 32'(4));
    for (int r = 16; r < 20; r++) begin
      read_row(r, d); check("tetris_row", 32'(d), 32'(0));
    end
`else
    check("tetris_cycles", 32'(cyc), 32'(2));
    check("tetris_lines", 32'(lines_cleared), 32'(0));
    for (int r = 16; r < 20; r++) begin
      read_row(r, d); check("tetris_row", 32'(d), 32'(10'h3FF));
    end
`endif

    // Collision
    do_reset();
    set_sq(10, 3, NR, 0, NR, 0, NR, 0); lock(cyc);
    read_row(10, d); check("coll_row10", 32'(d), 32'(10'h008));
    set_sq(9, 3, NR, 0, NR, 0, NR, 0); tick();
    check("coll_above_cell", 32'(collision), 32'(1));
    set_sq(9, 4, NR, 0, NR, 0, NR, 0); tick();
    check("coll_clear", 32'(collision), 32'(0));
    set_sq(5, 0, 5, 1, 19, 7, NR, 0); tick();
    check("coll_floor", 32'(collision), 32'(1));
    set_sq(NR, 0, NR, 0, NR, 0, 9, 3); tick();
    check("coll_slot4", 32'(collision), 32'(1));
    set_sq(19, 15, 25, 3, 9, 12, NR, 0); tick();
    check("coll_out_of_range", 32'(collision), 32'(0));
    set_sq(NR, 0, NR, 0, NR, 0, NR, 0);

    // lock_en while busy is ignored
`ifdef BOARD_LINE_CLEAR_EN
    set_sq(19, 0, 19, 1, 19, 2, 19, 3); lock(cyc);
    set_sq(19, 4, 19, 5, 19, 6, 19, 7); lock(cyc);
    set_sq(19, 8, 19, 9, NR, 0, NR, 0);
    lock_en = 1'b1;
    tick();
    lock_en = 1'b0;
    tick();
    tick();
    check("in_shift_busy", 32'(busy), 32'(1));
    set_sq(5, 5, 5, 6, NR, 0, NR, 0);
    lock_en = 1'b1;
    tick();
    lock_en = 1'b0;
    wait_idle(cyc);
    set_sq(NR, 0, NR, 0, NR, 0, NR, 0);
    read_row(5, d); check("ignored_row5", 32'(d), 32'(0));
    read_row(19, d); check("ignored_row19", 32'(d), 32'(0));
    check("ignored_lines", 32'(lines_cleared), 32'(1));
`else
    set_sq(5, 5, 5, 6, NR, 0, NR, 0);
    lock_en = 1'b1;
    tick();
    check("in_lock_busy", 32'(busy), 32'(1));
    tick();
    lock_en = 1'b0;
    check("ignored_busy", 32'(busy), 32'(0));
    set_sq(NR, 0, NR, 0, NR, 0, NR, 0);
    read_row(5, d); check("ignored_row5", 32'(d), 32'(10'h060));
`endif

    // game_over
    check("go_initial", 32'(game_over), 32'(0));
    set_sq(0, 12, NR, 0, NR, 0, NR, 0); lock(cyc);
    check("go_out_of_range", 32'(game_over), 32'(0));
    set_sq(0, 4, NR, 0, NR, 0, NR, 0); lock(cyc);
    check("go_set", 32'(game_over), 32'(1));
    read_row(0, d); check("go_row0", 32'(d), 32'(10'h010));
    set_sq(19, 0, NR, 0, NR, 0, NR, 0); lock(cyc);
    check("go_sticky", 32'(game_over), 32'(1));
    read_row(19, d); check("go_lock_continues", 32'(d), 32'(10'h001));
    do_reset();
    check("go_cleared_by_rst", 32'(game_over), 32'(0));

    // Asynchronous reset in the middle of an operation
    set_sq(10, 0, 10, 1, NR, 0, NR, 0); lock(cyc);
    set_sq(19, 0, 19, 1, 19, 2, 19, 3); lock(cyc);
    set_sq(19, 4, 19, 5, 19, 6, 19, 7); lock(cyc);
    set_sq(19, 8, 19, 9, NR, 0, NR, 0);
    rd_row  = 5'd10;
    lock_en = 1'b1;
    tick();
    lock_en = 1'b0;
`ifdef BOARD_LINE_CLEAR_EN
    tick();
    tick();
    tick();
    check("pre_rst_lines", 32'(lines_cleared), 32'(1));
`endif
    check("pre_rst_busy", 32'(busy), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    check("async_busy", 32'(busy), 32'(0));
    check("async_lines", 32'(lines_cleared), 32'(0));
    check("async_rd_data", 32'(rd_data), 32'(0));
    rst = 1'b0;
    set_sq(NR, 0, NR, 0, NR, 0, NR, 0);
    for (int r = 10; r < 12; r++) begin
      read_row(r, d); check("async_board", 32'(d), 32'(0));
    end
    read_row(19, d); check("async_row19", 32'(d), 32'(0));
    check("post_rst_busy", 32'(busy), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
